// File: rtl/mips_cpu_register_file.sv
// Architectural register file for the MIPS core: 32 GPRs plus HI/LO, two
// combinational read ports, optional same-cycle write-to-read bypass.
module mips_cpu_register_file #(
  parameter int BYPASS    = 0,
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        write_enable,
  input  logic [4:0]  reg_write_addr,
  input  logic [31:0] reg_write_data,
  input  logic [4:0]  read_addr_a,
  input  logic [4:0]  read_addr_b,
  output logic [31:0] read_data_a,
  output logic [31:0] read_data_b,
  input  logic        hi_write_enable,
  input  logic        lo_write_enable,
  input  logic [31:0] hi_write_data,
  input  logic [31:0] lo_write_data,
  output logic [31:0] hi_readdata,
  output logic [31:0] lo_readdata,
  output logic [31:0] register_v0
);

  logic [31:0] regs [REG_COUNT];
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic gpr_commit;
  logic hi_commit;
  logic lo_commit;

  // Qualified write strobes; $zero is never a legal GPR destination.
  assign gpr_commit = clk_enable && write_enable && (reg_write_addr != 5'd0);
  assign hi_commit  = clk_enable && hi_write_enable;
  assign lo_commit  = clk_enable && lo_write_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      if (gpr_commit) begin
        regs[reg_write_addr] <= reg_write_data;
      end
      if (hi_commit) begin
        hi_reg <= hi_write_data;
      end
      if (lo_commit) begin
        lo_reg <= lo_write_data;
      end
    end
  end

  // Address 0 is forced to zero here so that neither storage nor bypass can leak a value.
  always_comb begin
    read_data_a = '0;
    read_data_b = '0;
    if (read_addr_a != 5'd0) begin
      if ((BYPASS != 0) && gpr_commit && (reg_write_addr == read_addr_a)) begin
        read_data_a = reg_write_data;
      end else begin
        read_data_a = regs[read_addr_a];
      end
    end
    if (read_addr_b != 5'd0) begin
      if ((BYPASS != 0) && gpr_commit && (reg_write_addr == read_addr_b)) begin
        read_data_b = reg_write_data;
      end else begin
        read_data_b = regs[read_addr_b];
      end
    end
  end

  always_comb begin
    hi_readdata = hi_reg;
    lo_readdata = lo_reg;
    if ((BYPASS != 0) && hi_commit) begin
      hi_readdata = hi_write_data;
    end
    if ((BYPASS != 0) && lo_commit) begin
      lo_readdata = lo_write_data;
    end
  end

  // Debug tap: always the stored $v0, never bypassed.
  assign register_v0 = regs[2];

endmodule

// File: tb/tb_mips_cpu_register_file.sv
// Self-checking bench: drives a BYPASS=0 and a BYPASS=1 instance in lockstep
// against an array-based reference model plus hand-computed expectations.
module tb_mips_cpu_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        write_enable;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic [4:0]  read_addr_a;
  logic [4:0]  read_addr_b;
  logic        hi_write_enable;
  logic        lo_write_enable;
  logic [31:0] hi_write_data;
  logic [31:0] lo_write_data;

  logic [31:0] rda0, rdb0, hi0, lo0, v00;
  logic [31:0] rda1, rdb1, hi1, lo1, v01;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_regs [32];
  logic [31:0] model_hi;
  logic [31:0] model_lo;
  bit          model_valid = 1'b0;

  always #5 clk = ~clk;

  mips_cpu_register_file #(.BYPASS(0), .REG_COUNT(32)) dut0 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .write_enable(write_enable), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .read_addr_a(read_addr_a),
    .read_addr_b(read_addr_b), .read_data_a(rda0), .read_data_b(rdb0),
    .hi_write_enable(hi_write_enable), .lo_write_enable(lo_write_enable),
    .hi_write_data(hi_write_data), .lo_write_data(lo_write_data),
    .hi_readdata(hi0), .lo_readdata(lo0), .register_v0(v00)
  );

  mips_cpu_register_file #(.BYPASS(1), .REG_COUNT(32)) dut1 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .write_enable(write_enable), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data), .read_addr_a(read_addr_a),
    .read_addr_b(read_addr_b), .read_data_a(rda1), .read_data_b(rdb1),
    .hi_write_enable(hi_write_enable), .lo_write_enable(lo_write_enable),
    .hi_write_data(hi_write_data), .lo_write_data(lo_write_data),
    .hi_readdata(hi1), .lo_readdata(lo1), .register_v0(v01)
  );

  // Reference model: architectural state updated on every rising edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
      model_hi = 32'h0;
      model_lo = 32'h0;
      model_valid = 1'b1;
    end else if (clk_enable) begin
      if (write_enable && reg_write_addr != 5'd0) model_regs[reg_write_addr] = reg_write_data;
      if (hi_write_enable) model_hi = hi_write_data;
      if (lo_write_enable) model_lo = lo_write_data;
    end
  end

  function automatic logic [31:0] expGpr(input logic [4:0] addr, input bit byp);
    if (addr == 5'd0) return 32'h0;
    if (byp && clk_enable && write_enable && reg_write_addr == addr) return reg_write_data;
    return model_regs[addr];
  endfunction

  function automatic logic [31:0] expHi(input bit byp);
    return (byp && clk_enable && hi_write_enable) ? hi_write_data : model_hi;
  endfunction

  function automatic logic [31:0] expLo(input bit byp);
    return (byp && clk_enable && lo_write_enable) ? lo_write_data : model_lo;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model comparison on every falling edge once the first reset has been seen.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("m0.rda", rda0, expGpr(read_addr_a, 1'b0));
      checkOutput("m0.rdb", rdb0, expGpr(read_addr_b, 1'b0));
      checkOutput("m0.hi",  hi0,  expHi(1'b0));
      checkOutput("m0.lo",  lo0,  expLo(1'b0));
      checkOutput("m0.v0",  v00,  model_regs[2]);
      checkOutput("m1.rda", rda1, expGpr(read_addr_a, 1'b1));
      checkOutput("m1.rdb", rdb1, expGpr(read_addr_b, 1'b1));
      checkOutput("m1.hi",  hi1,  expHi(1'b1));
      checkOutput("m1.lo",  lo1,  expLo(1'b1));
      checkOutput("m1.v0",  v01,  model_regs[2]);
    end
  end

  task automatic applyStimulus(
    input logic rst, input logic ce,
    input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
    input logic hwe, input logic [31:0] hdata,
    input logic lwe, input logic [31:0] ldata,
    input logic [4:0] ra, input logic [4:0] rb);
    reset = rst; clk_enable = ce;
    write_enable = we; reg_write_addr = waddr; reg_write_data = wdata;
    hi_write_enable = hwe; hi_write_data = hdata;
    lo_write_enable = lwe; lo_write_data = ldata;
    read_addr_a = ra; read_addr_b = rb;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    applyStimulus(0, 1, 0, 5'd0, 32'h0, 0, 32'h0, 0, 32'h0, ra, rb);
  endtask

  initial begin
    applyStimulus(1, 1, 0, 5'd0, 32'h0, 0, 32'h0, 0, 32'h0, 5'd0, 5'd0);
    step();
    step();

    // Reset state
    idle(5'd5, 5'd2);
    checkOutput("reset.rda", rda0, 32'h0);
    checkOutput("reset.v0",  v00,  32'h0);
    checkOutput("reset.hi",  hi0,  32'h0);
    checkOutput("reset.lo",  lo1,  32'h0);

    // r5 and r2 writes, then read back
    applyStimulus(0, 1, 1, 5'd5, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0, 5'd5, 5'd2);
    step();
    applyStimulus(0, 1, 1, 5'd2, 32'h12345678, 0, 32'h0, 0, 32'h0, 5'd5, 5'd2);
    step();
    idle(5'd5, 5'd2);
    checkOutput("r5.read", rda0, 32'hDEADBEEF);
    checkOutput("v0.read", v00,  32'h12345678);
    checkOutput("r2.portb", rdb1, 32'h12345678);

    // Reset with a pending write discards it
    applyStimulus(1, 1, 1, 5'd9, 32'hCAFEF00D, 1, 32'h77, 1, 32'h88, 5'd5, 5'd9);
    step();
    idle(5'd5, 5'd9);
    checkOutput("rst.r5", rda0, 32'h0);
    checkOutput("rst.r9", rdb0, 32'h0);
    checkOutput("rst.v0", v00,  32'h0);
    checkOutput("rst.hi", hi0,  32'h0);

    // Writes to $zero are dropped, including on the bypass path
    applyStimulus(0, 1, 1, 5'd0, 32'hFFFFFFFF, 0, 32'h0, 0, 32'h0, 5'd0, 5'd0);
    checkOutput("zero.byp.a", rda1, 32'h0);
    checkOutput("zero.byp.b", rdb1, 32'h0);
    step();
    idle(5'd0, 5'd0);
    checkOutput("zero.a", rda0, 32'h0);
    checkOutput("zero.b", rdb0, 32'h0);

    // JAL link write to r31, then scan r0..r30
    applyStimulus(0, 1, 1, 5'd31, 32'h00400008, 0, 32'h0, 0, 32'h0, 5'd0, 5'd31);
    step();
    idle(5'd0, 5'd31);
    checkOutput("r31.read", rdb0, 32'h00400008);
    for (int i = 0; i < 31; i++) begin
      idle(5'(i), 5'd31);
      checkOutput("scan", rda0, 32'h0);
    end

    // Same-cycle read/write of r7
    applyStimulus(0, 1, 1, 5'd7, 32'h11, 0, 32'h0, 0, 32'h0, 5'd7, 5'd7);
    step();
    applyStimulus(0, 1, 1, 5'd7, 32'h22, 0, 32'h0, 0, 32'h0, 5'd7, 5'd7);
    checkOutput("r7.old",  rda0, 32'h11);
    checkOutput("r7.byp",  rda1, 32'h22);
    step();
    idle(5'd7, 5'd7);
    checkOutput("r7.new",  rda0, 32'h22);

    // Stall freezes everything; releasing it commits on that edge
    applyStimulus(0, 0, 1, 5'd3, 32'hAAAA, 1, 32'h5, 1, 32'h6, 5'd3, 5'd3);
    checkOutput("stall.byp", rda1, 32'h0);
    step();
    checkOutput("stall.r3", rda0, 32'h0);
    checkOutput("stall.hi", hi0,  32'h0);
    checkOutput("stall.lo", lo0,  32'h0);
    applyStimulus(0, 1, 1, 5'd3, 32'hAAAA, 1, 32'h5, 1, 32'h6, 5'd3, 5'd3);
    step();
    idle(5'd3, 5'd3);
    checkOutput("unstall.r3", rda0, 32'hAAAA);
    checkOutput("unstall.hi", hi0,  32'h5);
    checkOutput("unstall.lo", lo0,  32'h6);

    // Simultaneous GPR and HI/LO writes
    applyStimulus(0, 1, 1, 5'd4, 32'h3, 1, 32'h1, 1, 32'h2, 5'd4, 5'd4);
    checkOutput("sim.hibyp", hi1, 32'h1);
    checkOutput("sim.hiold", hi0, 32'h5);
    step();
    idle(5'd4, 5'd4);
    checkOutput("sim.hi", hi0,  32'h1);
    checkOutput("sim.lo", lo0,  32'h2);
    checkOutput("sim.r4", rda0, 32'h3);

    // Reset in the same cycle as writes
    applyStimulus(1, 1, 1, 5'd4, 32'h99, 1, 32'h7, 1, 32'h8, 5'd4, 5'd3);
    step();
    idle(5'd4, 5'd3);
    checkOutput("rstw.r4", rda0, 32'h0);
    checkOutput("rstw.r3", rdb0, 32'h0);
    checkOutput("rstw.hi", hi0,  32'h0);
    checkOutput("rstw.lo", lo0,  32'h0);

    // Mixed traffic checked by the model every cycle
    for (int i = 0; i < 60; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), $urandom,
                    1'($urandom_range(0, 1)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end
    idle(5'd0, 5'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
